// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard control: load-use stall, branch flush, multicycle mul/div stall
module hazard_control_unit #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRd,
    input  logic [4:0]  IF_ID_RegisterRs1,
    input  logic [4:0]  IF_ID_RegisterRs2,
    input  logic        EX_BranchTaken,
    input  logic        EX_MulDiv,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Bubble,
    output logic [31:0] StallCount,
    output logic [15:0] FlushCount,
    output logic [1:0]  ctrl_state
);

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] MD_BUSY = 2'b01;

    // The first EX cycle of a mul/div is spent in RUN and the release cycle
    // is spent with md_cnt==0, so the counter is preloaded with two less.
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [3:0]  md_cnt;
    logic [3:0]  md_cnt_next;
    logic [31:0] stall_count;
    logic [15:0] flush_count;

    logic in_busy;
    logic rd_matches;
    logic load_use;
    logic branch_flush;
    logic md_stall;

    // Encodings 2'b10/2'b11 are never entered; anything but MD_BUSY acts as RUN.
    assign in_busy = (state == MD_BUSY);

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign rd_matches = (ID_EX_RegisterRd != 5'd0) &&
                        ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                         (ID_EX_RegisterRd == IF_ID_RegisterRs2));

    // Mul/div dominates everything, then a taken branch, then load-use.
    assign load_use     = ID_EX_MemRead && rd_matches && !EX_MulDiv && !EX_BranchTaken;
    assign branch_flush = EX_BranchTaken && !EX_MulDiv;
    assign md_stall     = in_busy ? (md_cnt != 4'd0) : EX_MulDiv;

    // Pipeline enables, flushes and bubble; reset forces the defaults.
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        if (!reset) begin
            if (md_stall) begin
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Bubble = 1'b1;
            end else if (!in_busy) begin
                if (branch_flush) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
        end
    end

    // Next state and mul/div occupancy counter.
    always_comb begin
        state_next  = RUN;
        md_cnt_next = md_cnt;
        if (in_busy) begin
            if (md_cnt != 4'd0) begin
                state_next  = MD_BUSY;
                md_cnt_next = md_cnt - 4'd1;
            end
        end else if (EX_MulDiv) begin
            state_next  = MD_BUSY;
            md_cnt_next = MD_LOAD;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if (!PCWrite && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    // Saturating count of taken-branch flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count <= 16'd0;
        end else if (IF_ID_Flush && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
        end
    end

    assign StallCount = stall_count;
    assign FlushCount = flush_count;
    assign ctrl_state = reset ? RUN : state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegisterRd;
    logic [4:0]  IF_ID_RegisterRs1;
    logic [4:0]  IF_ID_RegisterRs2;
    logic        EX_BranchTaken;
    logic        EX_MulDiv;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        EX_MEM_Bubble;
    logic [31:0] StallCount;
    logic [15:0] FlushCount;
    logic [1:0]  ctrl_state;

    int checks = 0;
    int errors = 0;

    hazard_control_unit #(.MD_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_RegisterRd  (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
        .EX_BranchTaken    (EX_BranchTaken),
        .EX_MulDiv         (EX_MulDiv),
        .PCWrite           (PCWrite),
        .IF_ID_Write       (IF_ID_Write),
        .ID_EX_Write       (ID_EX_Write),
        .IF_ID_Flush       (IF_ID_Flush),
        .ID_EX_Flush       (ID_EX_Flush),
        .EX_MEM_Bubble     (EX_MEM_Bubble),
        .StallCount        (StallCount),
        .FlushCount        (FlushCount),
        .ctrl_state        (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble}
    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check({tag, ".PCWrite"},       32'(PCWrite),       32'(exp[5]));
        check({tag, ".IF_ID_Write"},   32'(IF_ID_Write),   32'(exp[4]));
        check({tag, ".ID_EX_Write"},   32'(ID_EX_Write),   32'(exp[3]));
        check({tag, ".IF_ID_Flush"},   32'(IF_ID_Flush),   32'(exp[2]));
        check({tag, ".ID_EX_Flush"},   32'(ID_EX_Flush),   32'(exp[1]));
        check({tag, ".EX_MEM_Bubble"}, 32'(EX_MEM_Bubble), 32'(exp[0]));
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic br, input logic md);
        ID_EX_MemRead     = mr;
        ID_EX_RegisterRd  = rd;
        IF_ID_RegisterRs1 = rs1;
        IF_ID_RegisterRs2 = rs2;
        EX_BranchTaken    = br;
        EX_MulDiv         = md;
    endtask

    localparam logic [5:0] C_DEF    = 6'b111_000;
    localparam logic [5:0] C_LDUSE  = 6'b001_010;
    localparam logic [5:0] C_BRANCH = 6'b111_110;
    localparam logic [5:0] C_MD     = 6'b000_001;

    initial begin
        // Reset held with hostile inputs: outputs must be defaults.
        reset = 1'b1;
        set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check_ctrl("rst_out", C_DEF);
        check("rst_state", 32'(ctrl_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("rst_stall", StallCount, 32'd0);
        check("rst_flush", 32'(FlushCount), 32'd0);
        check_ctrl("idle", C_DEF);
        @(negedge clk);

        // Load x5 in EX, rs2 of ID reads x5.
        set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
        #1;
        check_ctrl("lu_rs2", C_LDUSE);
        check("lu_rs2_state", 32'(ctrl_state), 32'd0);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("lu_rs2_cnt", StallCount, 32'd1);
        check("lu_rs2_state2", 32'(ctrl_state), 32'd0);
        check_ctrl("lu_after", C_DEF);
        @(negedge clk);

        // Load to x0 never stalls.
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check_ctrl("lu_x0", C_DEF);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("lu_x0_cnt", StallCount, 32'd1);

        // Non-load with matching register: no stall.
        set_in(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
        #1;
        check_ctrl("nonload", C_DEF);
        @(negedge clk);

        // rs1 match.
        set_in(1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0);
        #1;
        check_ctrl("lu_rs1", C_LDUSE);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("lu_rs1_cnt", StallCount, 32'd2);

        // Taken branch overrides concurrent load-use.
        set_in(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0);
        #1;
        check_ctrl("br_lu", C_BRANCH);
        @(negedge clk);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("br_flushcnt", 32'(FlushCount), 32'd1);
        check("br_stallcnt", StallCount, 32'd2);

        // Mul/div held 4 cycles; branch and load-use asserted too, all ignored.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd9, 5'd9, 5'd0, (i == 0), 1'b1);
            #1;
            check($sformatf("md_state%0d", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            check_ctrl($sformatf("md_out%0d", i), (i < 3) ? C_MD : C_DEF);
            @(negedge clk);
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("md_stallcnt", StallCount, 32'd5);
        check("md_flushcnt", 32'(FlushCount), 32'd1);
        check("md_back_run", 32'(ctrl_state), 32'd0);
        @(negedge clk);

        // Back-to-back mul/div: restart straight after the release cycle.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            #1;
            check($sformatf("b2b_state%0d", i), 32'(ctrl_state), ((i % 4) == 0) ? 32'd0 : 32'd1);
            check($sformatf("b2b_pcw%0d", i), 32'(PCWrite), ((i % 4) == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("b2b_stallcnt", StallCount, 32'd11);
        @(negedge clk);

        // Reset during the second MD_BUSY cycle.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_state", 32'(ctrl_state), 32'd1);
        reset = 1'b1;
        set_in(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1);
        #1;
        check_ctrl("midrst_out", C_DEF);
        check("midrst_state", 32'(ctrl_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("postrst_state", 32'(ctrl_state), 32'd0);
        check("postrst_stall", StallCount, 32'd0);
        check("postrst_flush", 32'(FlushCount), 32'd0);
        check_ctrl("postrst_out", C_DEF);
        @(negedge clk);

        // StallCount saturation.
        dut.stall_count = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            #1;
            check($sformatf("sat_stall%0d", i), StallCount, 32'hFFFF_FFFF);
        end

        // FlushCount saturation.
        dut.flush_count = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
            @(negedge clk);
            #1;
            check($sformatf("sat_flush%0d", i), 32'(FlushCount), 32'h0000_FFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MD_CYCLES, default 4, total EX-stage occupancy in cycles of a multiply/divide op; legal range 2..15.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-005 ID_EX_RegisterRd  input  5  destination register of instruction in EX.
REQ-006 IF_ID_RegisterRs1  input  5  rs1 of instruction in ID.
REQ-007 IF_ID_RegisterRs2  input  5  rs2 of instruction in ID.
REQ-008 EX_BranchTaken  input  1  branch/jump in EX resolved taken; PC redirect this cycle.
REQ-009 EX_MulDiv  input  1  instruction in EX is a multicycle multiply/divide.
REQ-010 PCWrite  output  1  PC update enable.
REQ-011 IF_ID_Write  output  1  IF/ID register load enable.
REQ-012 ID_EX_Write  output  1  ID/EX register load enable.
REQ-013 IF_ID_Flush  output  1  zero IF/ID on next edge.
REQ-014 ID_EX_Flush  output  1  load bubble (all controls 0) into ID/EX on next edge.
REQ-015 EX_MEM_Bubble  output  1  load bubble into EX/MEM on next edge.
REQ-016 StallCount  output  32  cycles with PCWrite=0, saturating.
REQ-017 FlushCount  output  16  taken-branch flushes, saturating.
REQ-018 ctrl_state  output  2  current state encoding, for debug.

Function
REQ-019 States SHALL be RUN=2'b00 and MD_BUSY=2'b01; 2'b10/2'b11 unreachable, decoded as RUN.
REQ-020 Outputs REQ-010..015 SHALL be combinational from state, md_cnt and inputs; defaults: enables 1, flushes/bubble 0.
REQ-021 Load-use: in RUN, ID_EX_MemRead=1, ID_EX_RegisterRd!=0, Rd equals Rs1 or Rs2, EX_MulDiv=0, EX_BranchTaken=0 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly that cycle; state remains RUN.
REQ-022 Branch: EX_BranchTaken=1 and EX_MulDiv=0 -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1; overrides a simultaneous load-use.
REQ-023 Mul/div start: in RUN with EX_MulDiv=1 -> PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1; next state MD_BUSY, md_cnt loaded with MD_CYCLES-2.
REQ-024 In MD_BUSY with md_cnt!=0: same four stall outputs as REQ-023; md_cnt decrements; state holds.
REQ-025 In MD_BUSY with md_cnt==0 (release cycle): default outputs; next state RUN; pipeline advances.
REQ-026 Net effect: each mul/div stalls the front end exactly MD_CYCLES-1 cycles; back-to-back mul/div restarts from RUN with no gap.
REQ-027 EX_MulDiv=1 SHALL take priority over EX_BranchTaken and load-use (mutually exclusive in legal code; branch ignored).
REQ-028 In MD_BUSY, EX_BranchTaken and load-use conditions SHALL be ignored.
REQ-029 md_cnt width 4 bits; no underflow path.
REQ-030 StallCount +1 every cycle PCWrite=0; holds at 32'hFFFFFFFF.
REQ-031 FlushCount +1 every cycle REQ-022 flush fires; holds at 16'hFFFF.

Reset
REQ-032 reset=1 at a clock edge SHALL set state=RUN, md_cnt=0, StallCount=0, FlushCount=0, regardless of current state, including mid-MD_BUSY.
REQ-033 While reset=1, outputs REQ-010..015 SHALL take defaults (enables 1, flushes/bubble 0), ignoring inputs; ctrl_state=2'b00.

Verification
REQ-034 Load x5 in EX (MemRead=1, Rd=5), ID Rs2=5 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount 0->1.
REQ-035 Same with Rd=0 -> no stall, all defaults.
REQ-036 EX_MulDiv=1 held, MD_CYCLES=4 -> stall outputs 3 cycles, ctrl_state 00,01,01,01, release on 4th, StallCount=3.
REQ-037 EX_BranchTaken=1 with concurrent load-use -> IF_ID_Flush=ID_EX_Flush=1, PCWrite=1, FlushCount 0->1, StallCount unchanged.
REQ-038 reset asserted during second MD_BUSY cycle -> next cycle ctrl_state=00, counters 0, outputs default.
REQ-039 Force StallCount to 32'hFFFFFFFE, then 3 stall cycles -> saturates at 32'hFFFFFFFF.
